// File: rtl/countdown_game_ctrl.sv
// Countdown game controller: button-driven BCD preset entry, 1-per-tick BCD countdown, blink at zero.
// All outputs registered; button pulses act on the edge that samples them and show one cycle later.
module countdown_game_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_inc,
  input  logic        btn_next,
  input  logic        btn_start,
  input  logic        btn_clear,
  output logic        enWrite,
  output logic [1:0]  digLoc,
  output logic [3:0]  digValue,
  output logic [15:0] counter,
  output logic        gameStarted,
  output logic        gameFinished,
  output logic        blink
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [3:0][3:0]      preset, preset_nxt;
  logic [TICK_W-1:0]    tick_cnt, tick_nxt;
  logic [BLINK_W-1:0]   blink_cnt, blink_cnt_nxt;
  logic                 wr_nxt;
  logic [1:0]           loc_nxt;
  logic [3:0]           val_nxt;
  logic [15:0]          cnt_nxt;
  logic                 started_nxt, finished_nxt, blink_nxt;

  logic [3:0]           cur_digit, inc_digit;
  logic [1:0]           loc_inc;
  logic [15:0]          dec_value;
  logic                 tick_wrap, blink_wrap;

  // Borrow ripples upward only through digits that were already zero.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign cur_digit  = preset[digLoc];
  assign inc_digit  = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
  assign loc_inc    = digLoc + 2'd1;
  assign dec_value  = bcd_dec(counter);
  assign tick_wrap  = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

  always_comb begin
    state_nxt     = state;
    preset_nxt    = preset;
    tick_nxt      = tick_cnt;
    blink_cnt_nxt = blink_cnt;
    wr_nxt        = 1'b0;
    loc_nxt       = digLoc;
    val_nxt       = digValue;
    cnt_nxt       = counter;
    started_nxt   = gameStarted;
    finished_nxt  = gameFinished;
    blink_nxt     = blink;

    case (state)
      SETUP: begin
        cnt_nxt      = 16'h0000;
        started_nxt  = 1'b0;
        finished_nxt = 1'b0;
        blink_nxt    = 1'b0;
        // A start pulse outranks inc/next even when it is ignored for a zero preset.
        if (btn_clear) begin
          preset_nxt = '0;
          loc_nxt    = 2'd0;
          val_nxt    = 4'd0;
          wr_nxt     = 1'b1;
        end else if (btn_start) begin
          if (preset != '0) begin
            cnt_nxt     = preset;
            tick_nxt    = '0;
            started_nxt = 1'b1;
            state_nxt   = RUN;
          end
        end else if (btn_inc) begin
          preset_nxt[digLoc] = inc_digit;
          val_nxt            = inc_digit;
          wr_nxt             = 1'b1;
        end else if (btn_next) begin
          loc_nxt = loc_inc;
          val_nxt = preset[loc_inc];
          wr_nxt  = 1'b1;
        end
      end

      RUN: begin
        if (btn_clear) begin
          state_nxt   = SETUP;
          cnt_nxt     = 16'h0000;
          started_nxt = 1'b0;
          tick_nxt    = '0;
        end else if (tick_wrap) begin
          tick_nxt = '0;
          cnt_nxt  = dec_value;
          if (counter == 16'h0001) begin
            state_nxt     = DONE;
            started_nxt   = 1'b0;
            finished_nxt  = 1'b1;
            blink_nxt     = 1'b1;
            blink_cnt_nxt = '0;
          end
        end else begin
          tick_nxt = tick_cnt + TICK_W'(1);
        end
      end

      DONE: begin
        cnt_nxt = 16'h0000;
        if (btn_clear) begin
          state_nxt     = SETUP;
          finished_nxt  = 1'b0;
          blink_nxt     = 1'b0;
          blink_cnt_nxt = '0;
        end else if (blink_wrap) begin
          blink_cnt_nxt = '0;
          blink_nxt     = ~blink;
        end else begin
          blink_cnt_nxt = blink_cnt + BLINK_W'(1);
        end
      end

      default: begin
        state_nxt    = SETUP;
        cnt_nxt      = 16'h0000;
        started_nxt  = 1'b0;
        finished_nxt = 1'b0;
        blink_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SETUP;
      preset       <= '0;
      tick_cnt     <= '0;
      blink_cnt    <= '0;
      enWrite      <= 1'b0;
      digLoc       <= 2'd0;
      digValue     <= 4'd0;
      counter      <= 16'h0000;
      gameStarted  <= 1'b0;
      gameFinished <= 1'b0;
      blink        <= 1'b0;
    end else begin
      state        <= state_nxt;
      preset       <= preset_nxt;
      tick_cnt     <= tick_nxt;
      blink_cnt    <= blink_cnt_nxt;
      enWrite      <= wr_nxt;
      digLoc       <= loc_nxt;
      digValue     <= val_nxt;
      counter      <= cnt_nxt;
      gameStarted  <= started_nxt;
      gameFinished <= finished_nxt;
      blink        <= blink_nxt;
    end
  end

endmodule
